// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and constants for the byte-serial memory
//               controller: address/word/byte types, access-size encodings,
//               FSM state encoding, and helper functions for size
//               normalisation and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    // Access-size encodings (bytes per access).
    localparam logic [2:0] C_SIZE_BYTE = 3'd1;
    localparam logic [2:0] C_SIZE_HALF = 3'd2;
    localparam logic [2:0] C_SIZE_WORD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Any encoding other than byte or halfword is a full word.
    function automatic logic [2:0] size_bytes(input logic [2:0] sz);
        logic [2:0] n;
        case (sz)
            C_SIZE_BYTE: n = C_SIZE_BYTE;
            C_SIZE_HALF: n = C_SIZE_HALF;
            default:     n = C_SIZE_WORD;
        endcase
        return n;
    endfunction

    // Zero- or sign-extend a 1/2-byte load; words pass through unchanged.
    function automatic word_t load_extend(input word_t raw, input logic [2:0] nbytes,
                                          input logic sgn);
        word_t r;
        case (nbytes)
            C_SIZE_BYTE: r = {{24{sgn & raw[7]}},  raw[7:0]};
            C_SIZE_HALF: r = {{16{sgn & raw[15]}}, raw[15:0]};
            default:     r = raw;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Byte-serial memory controller. Accepts 1/2/4-byte loads and
//               stores and sequences them over an 8-bit memory bus, one byte
//               per cycle, little-endian. Reads are pipelined against a
//               one-cycle-latency memory (address in cycle k, data in k+1).
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   rdy               : global stall-enable; low freezes all state
//   req_en/req_ready  : request handshake (accepted when both high)
//   req_wr            : 1=store, 0=load
//   req_addr/size     : byte address of lowest byte, size in bytes (1/2/4)
//   req_signed        : sign-extend sub-word loads
//   req_data          : store data (low bytes used)
//   done, rdata       : completion pulse and load result (held to next done)
//   mem_a/mem_dout    : memory byte address and write byte
//   mem_din           : memory read byte
//   mem_wr            : memory write strobe
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_en,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_data,
    output logic        req_ready,
    output logic        done,
    output logic [31:0] rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_t      r_state;
    logic [2:0]  r_idx;      // byte index within the access (0..n on reads)
    logic [2:0]  r_n;        // normalised access size in bytes
    logic        r_signed;
    word_t       r_wdata;
    word_t       r_buf;      // load bytes assembled so far
    word_t       r_rdata;
    addr_t       r_mem_a;    // doubles as the latched access address
    byte_t       r_mem_dout;
    logic        r_mem_wr;
    logic        r_ready;
    logic        r_done;

    logic [2:0]  w_idx_nxt;
    logic [1:0]  w_cap_sel;  // byte lane receiving mem_din this cycle
    logic [1:0]  w_wr_sel;   // byte lane driven in the next write cycle
    word_t       w_buf_next;

    assign w_idx_nxt = r_idx + 3'd1;
    // Read cycle k captures byte k-1; for k=4 the 2-bit wrap gives lane 3.
    assign w_cap_sel = r_idx[1:0] - 2'd1;
    assign w_wr_sel  = r_idx[1:0] + 2'd1;

    // Buffer including the byte arriving this cycle, so the final capture
    // and the rdata update happen on the same edge.
    always_comb begin
        w_buf_next = r_buf;
        if (r_idx != 3'd0) begin
            w_buf_next[{w_cap_sel, 3'b000} +: 8] = mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 3'd0;
            r_n        <= C_SIZE_WORD;
            r_signed   <= 1'b0;
            r_wdata    <= '0;
            r_buf      <= '0;
            r_rdata    <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (req_en) begin
                        r_mem_a  <= req_addr;
                        r_n      <= size_bytes(req_size);
                        r_signed <= req_signed;
                        r_wdata  <= req_data;
                        r_buf    <= '0;
                        r_idx    <= 3'd0;
                        r_ready  <= 1'b0;
                        if (req_wr) begin
                            r_state    <= ST_WRITE;
                            r_mem_dout <= req_data[7:0];
                            r_mem_wr   <= 1'b1;
                        end else begin
                            r_state  <= ST_READ;
                            r_mem_wr <= 1'b0;
                        end
                    end
                end

                ST_READ: begin
                    r_buf <= w_buf_next;
                    if (r_idx == r_n) begin
                        // Extra cycle: last byte lands now.
                        r_rdata <= load_extend(w_buf_next, r_n, r_signed);
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= w_idx_nxt;
                        // Hold the last byte address during the extra cycle.
                        if (w_idx_nxt < r_n) begin
                            r_mem_a <= r_mem_a + 32'd1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (r_idx == (r_n - 3'd1)) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_mem_wr <= 1'b0;
                    end else begin
                        r_idx      <= w_idx_nxt;
                        r_mem_a    <= r_mem_a + 32'd1;
                        r_mem_dout <= r_wdata[{w_wr_sel, 3'b000} +: 8];
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign mem_a     = r_mem_a;
    assign mem_dout  = r_mem_dout;
    // A stalled cycle must not write; the strobe reappears on resume.
    assign mem_wr    = r_mem_wr & rdy;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl. A byte-array memory with
//               one-cycle read latency (stalled along with the controller by
//               rdy) sits on the bus; each access is checked cycle by cycle
//               against the expected bus trace, latency and load result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        req_en;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic        req_signed;
    logic [31:0] req_data;
    logic        req_ready;
    logic        done;
    logic [31:0] rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int          total;
    int          bad;
    logic [31:0] last_rdata;
    logic [7:0]  mem [256];   // bench memory, aliased on the low address byte

    mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .req_en     (req_en),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .done       (done),
        .rdata      (rdata),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read memory; it stalls with the rest of the system.
    always @(posedge clk) begin
        if (rdy) mem_din <= mem[mem_a[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access. Stall cycles are numbered from the first cycle
    // after acceptance (c=1); st_at must not exceed the unstalled position
    // of the last busy cycle so the done cycle itself is never stalled.
    task automatic access(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic sg, input logic [31:0] d,
                          input int st_at, input int st_len);
        int          n;
        int          pd;
        int          p;
        logic [31:0] exp_rd;
        logic [31:0] ea;
        logic [7:0]  b;
        n  = (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
        pd = wr ? n : n + 1;
        exp_rd = 32'd0;
        for (int k = 0; k < n; k++) begin
            ea = a + k[31:0];
            b  = mem[ea[7:0]];
            exp_rd = exp_rd | ({24'd0, b} << (8 * k));
        end
        if (!wr && sg && n < 4 && exp_rd[8*n-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * n));

        @(posedge clk); #1;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        req_en = 1'b1; req_wr = wr; req_addr = a; req_size = sz;
        req_signed = sg; req_data = d; rdy = 1'b1;
        p = 0;
        for (int c = 1; c <= 40 && p <= pd; c++) begin
            @(posedge clk); #1;
            rdy        = !(c >= st_at && c < st_at + st_len);
            req_en     = 1'($urandom_range(0, 1));   // must be ignored while busy
            req_wr     = 1'($urandom_range(0, 1));
            req_addr   = $urandom;
            req_size   = 3'($urandom_range(0, 7));
            req_signed = 1'($urandom_range(0, 1));
            req_data   = $urandom;
            #1;
            ea = a + ((p < n) ? p[31:0] : n[31:0] - 32'd1);
            if (p == pd) begin
                chk("done_pulse", {31'd0, done}, 32'd1);
                chk("done_ready", {31'd0, req_ready}, 32'd0);
                chk("done_wr", {31'd0, mem_wr}, 32'd0);
                chk("latency", c[31:0], pd[31:0] + 32'd1 + st_len[31:0]);
                if (!wr) begin
                    chk("rdata", rdata, exp_rd);
                    last_rdata = exp_rd;
                end
                p++;
            end else begin
                chk("busy_done", {31'd0, done}, 32'd0);
                chk("busy_ready", {31'd0, req_ready}, 32'd0);
                chk("mem_a", mem_a, ea);
                if (wr && rdy) begin
                    chk("wr_strobe", {31'd0, mem_wr}, 32'd1);
                    chk("wr_byte", {24'd0, mem_dout}, (d >> (8 * p)) & 32'hFF);
                    mem[ea[7:0]] = d[8*p +: 8];
                end else begin
                    chk("no_strobe", {31'd0, mem_wr}, 32'd0);
                end
                if (rdy) p++;
            end
        end
        chk("bounded", p[31:0], pd[31:0] + 32'd1);

        @(posedge clk); #1;
        req_en = 1'b0; rdy = 1'b1;
        #1;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_wr", {31'd0, mem_wr}, 32'd0);
        chk("idle_a_hold", mem_a, a + n[31:0] - 32'd1);
        chk("rdata_hold", rdata, last_rdata);
        if (wr) chk("idle_dout_hold", {24'd0, mem_dout}, (d >> (8 * (n - 1))) & 32'hFF);
    endtask

    logic [31:0] rnd_d;
    logic [31:0] rnd_a;
    logic [2:0]  rnd_sz;
    logic        rnd_wr;
    int          rnd_n;
    int          rnd_pd;

    initial begin
        total = 0; bad = 0; last_rdata = 32'd0;
        rst = 1'b1; rdy = 1'b1; req_en = 1'b0; req_wr = 1'b0; req_addr = 32'd0;
        req_size = 3'd0; req_signed = 1'b0; req_data = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
        mem[8'h05] = 8'h80;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr}, 32'd0);
        rst = 1'b0;

        // Word load, signed/unsigned byte loads with fixed expected results.
        access(1'b0, 32'h0000_0100, 3'd4, 1'b0, 32'd0, 0, 0);
        chk("ld_word_val", rdata, 32'h4433_2211);
        access(1'b0, 32'h0000_0005, 3'd1, 1'b1, 32'd0, 0, 0);
        chk("ld_sbyte_val", rdata, 32'hFFFF_FF80);
        access(1'b0, 32'h0000_0005, 3'd1, 1'b0, 32'd0, 0, 0);
        chk("ld_ubyte_val", rdata, 32'h0000_0080);

        // Halfword store into I/O space, then read it back.
        access(1'b1, 32'h0003_0000, 3'd2, 1'b0, 32'h0000_BEEF, 0, 0);
        access(1'b0, 32'h0003_0000, 3'd2, 1'b0, 32'd0, 0, 0);
        chk("st_half_back", rdata, 32'h0000_BEEF);

        // Two stall cycles during READ cycle 2 of a word load.
        access(1'b0, 32'h0000_0100, 3'd4, 1'b0, 32'd0, 3, 2);
        // Stall during a write byte: it must be re-issued.
        access(1'b1, 32'h0000_0040, 3'd4, 1'b0, 32'hCAFE_F00D, 2, 1);

        // Reset during WRITE cycle 1 (with rdy low, reset still wins).
        @(posedge clk); #1;
        req_en = 1'b1; req_wr = 1'b1; req_addr = 32'h0000_0200; req_size = 3'd4;
        req_data = 32'h5566_7788; rdy = 1'b1;
        @(posedge clk); #1;
        req_en = 1'b0;
        #1;
        chk("rstw_strobe0", {31'd0, mem_wr}, 32'd1);
        chk("rstw_addr0", mem_a, 32'h0000_0200);
        mem[8'h00] = 8'h88;
        @(posedge clk); #1;
        rst = 1'b1; rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b1;
        #1;
        chk("rstw_wr", {31'd0, mem_wr}, 32'd0);
        chk("rstw_done", {31'd0, done}, 32'd0);
        chk("rstw_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw_rdata", rdata, 32'd0);
        last_rdata = 32'd0;
        access(1'b0, 32'h0000_0000, 3'd4, 1'b0, 32'd0, 0, 0);

        // Address wrap across 2^32.
        access(1'b0, 32'hFFFF_FFFE, 3'd4, 1'b0, 32'd0, 0, 0);

        // Randomized accesses, including non-1/2 size codes and stalls.
        for (int i = 0; i < 30; i++) begin
            rnd_wr = 1'($urandom_range(0, 1));
            rnd_sz = 3'($urandom_range(0, 7));
            rnd_n  = (rnd_sz == 3'd1) ? 1 : (rnd_sz == 3'd2) ? 2 : 4;
            rnd_pd = rnd_wr ? rnd_n : rnd_n + 1;
            rnd_a  = (i % 5 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            rnd_d  = $urandom;
            access(rnd_wr, rnd_a, rnd_sz, 1'($urandom_range(0, 1)), rnd_d,
                   $urandom_range(1, rnd_pd), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
